osd_upsample_rd_ctrl: RTL and testbench
=======================================

Name: osd_upsample_rd_ctrl

Overview:
- Read-side sequencer for the OSD region RAM that feeds the picture-in-region overlay display block.
- Converts the display's per-pixel region-active strobe and frame-start pulse into RAM read addresses for an SRC_W x SRC_H source image, replicating each source pixel SCALE times horizontally and each source line SCALE times vertically (default 32x32 -> 64x64).
- Owns a two-bank ping-pong handshake with the RAM writer, so a new source frame is only displayed from the next frame boundary.

Parameters:
- SRC_W, 32, source image width in pixels
- SRC_H, 32, source image height in lines
- SCALE, 2, replication factor per axis (>=1)
- ADDR_W, 11, RAM address width; MSB is the bank bit; SRC_W*SRC_H <= 2^(ADDR_W-1)

Ports:
- pclk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- i_frame_rst  in  1  one-cycle frame-start pulse from the display block's RAM address-reset output
- i_region_active  in  1  high for each display pixel inside the overlay region
- i_wr_done  in  1  one-cycle pulse: writer finished filling bank o_wr_bank
- o_rd_en  out  1  RAM read enable
- o_rd_addr  out  ADDR_W  RAM read address {rd_bank, pixel_index}
- o_wr_bank  out  1  bank the writer may fill (always ~rd_bank)
- o_busy  out  1  high in ACTIVE state
- o_frame_done  out  1  one-cycle pulse when the last output line of the region ends
- o_overrun  out  1  sticky error: region line longer than SRC_W*SCALE pixels

Behaviour:
- Reset (rst_n=0 at a pclk edge):
  - state=WAIT_FRAME; all counters 0; rd_bank=0; pending=0.
  - Outputs: o_rd_en=0, o_rd_addr=0, o_wr_bank=1, o_busy=0, o_frame_done=0, o_overrun=0.
  - A reset mid-frame abandons the frame; nothing is read until the next i_frame_rst.
- State registers: src_x, h_rep (0..SCALE-1), v_rep, src_y, line_base (=src_y*SRC_W, maintained by adding SRC_W; no multiplier), rd_bank, pending, act_d (i_region_active delayed 1 cycle).
- States:
  - WAIT_FRAME -> ACTIVE on i_frame_rst.
  - ACTIVE -> DONE at the end of the final output line.
  - DONE -> ACTIVE on i_frame_rst.
  - i_frame_rst in any state: clear src_x, h_rep, v_rep, src_y, line_base and o_overrun; enter ACTIVE.
- Address timing:
  - o_rd_en = i_region_active & (state==ACTIVE). This is combinational from registers plus the input.
  - o_rd_addr = {rd_bank, line_base+src_x} from registered state. It is presented in the same cycle as the region-active pixel, so RAM data returns one cycle later, aligned with region_active delayed by one.
  - In WAIT_FRAME and DONE: o_rd_en=0, and o_rd_addr holds its last value.
- Pixel advance, on each cycle with o_rd_en=1:
  - if h_rep<SCALE-1: h_rep++.
  - else h_rep=0 and src_x++.
  - At src_x==SRC_W-1 with h_rep==SCALE-1: src_x and h_rep hold, and o_overrun sets if a further active pixel arrives.
- Line end = falling edge of region active (act_d=1, i_region_active=0) while in ACTIVE:
  - src_x=0, h_rep=0.
  - if v_rep<SCALE-1: v_rep++ (the same source line is repeated).
  - else v_rep=0; then:
    - if src_y==SRC_H-1: enter DONE and pulse o_frame_done for 1 cycle.
    - otherwise src_y++ and line_base+=SRC_W.
  - A short line (fewer than SRC_W*SCALE pixels) is not an error; the counters simply realign at the next line.
- Bank handshake:
  - pending_next = i_wr_done | (pending & ~i_frame_rst).
  - On i_frame_rst with old pending=1, rd_bank toggles.
  - i_wr_done coincident with i_frame_rst: the swap uses the old pending, and pending is then set again by the new pulse.
  - i_wr_done while pending=1: no change (the frame is overwritten, not queued).
  - o_wr_bank updates in the same cycle rd_bank toggles.
- Simultaneous i_frame_rst and line end: i_frame_rst wins, and o_frame_done is not pulsed.
- Widths: pixel_index is ADDR_W-1 bits. Additions never wrap within a valid frame.

Decomposition:
- Shared package osd_pkg holds:
  - state enum (WAIT_FRAME, ACTIVE, DONE)
  - default OSD geometry constants: SRC_W, SRC_H, SCALE, and the overlay size of 64.
- One sub-module, osd_rep_counter: a modulo-SCALE repeat counter with an advance input and a wrap output, instantiated for horizontal and vertical replication.
- The line/pixel counters and bank logic stay in the top module.

Test Plan:
- Nominal frame (defaults):
  - Stimulus: i_frame_rst, then 64 lines each with 64 active cycles and a gap of at least 1.
  - Required response:
    - Line 0 address sequence 0,0,1,1,...,31,31.
    - Line 1 identical to line 0; line 2 starts at 32.
    - Last line ends at 1023.
    - o_frame_done pulses once after line 64.
    - o_overrun=0.
- Bank swap:
  - Stimulus: i_wr_done mid-frame, then i_frame_rst.
  - Required response: the next frame's addresses are 1024..2047, o_wr_bank=0, pending clears.
  - A frame without i_wr_done keeps its bank.
- Coincident pulses:
  - Stimulus: pending=1; i_wr_done and i_frame_rst in the same cycle.
  - Required response: rd_bank toggles and pending stays 1.
  - The following i_frame_rst toggles again.
- Overrun:
  - Stimulus: one line with 70 active cycles.
  - Required response: addresses saturate at 31 from cycle 64 on, and o_overrun sets.
  - The next i_frame_rst clears o_overrun.
- Done and extra lines:
  - Stimulus: 66 region lines in one frame.
  - Required response: o_rd_en=0 for lines 65–66, o_busy=0, and o_frame_done pulses only once.
- Reset mid-frame:
  - Stimulus: rst_n=0 for 1 cycle during line 10, then more active lines.
  - Required response: all outputs at reset values and no o_rd_en until i_frame_rst.
  - Rd_bank=0 after reset.

Source files
------------

// File: rtl/osd_pkg.sv
// osd_pkg
// Shared definitions for the OSD region-RAM read path: the read sequencer
// state encoding and the default overlay geometry (32x32 source shown as
// 64x64 on screen).
package osd_pkg;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    DONE       = 2'd2
  } osd_state_e;

  localparam int OSD_SRC_W    = 32;
  localparam int OSD_SRC_H    = 32;
  localparam int OSD_SCALE    = 2;
  localparam int OSD_OVL_SIZE = OSD_SRC_W * OSD_SCALE;

endpackage

// File: rtl/osd_rep_counter.sv
// osd_rep_counter
// Modulo-SCALE repeat counter used to replicate pixels/lines.
// Ports:
//   pclk      in  pixel clock
//   rst_n     in  synchronous active-low reset
//   clr_i     in  return count to 0 (wins over adv_i)
//   adv_i     in  advance by one, wrapping SCALE-1 -> 0
//   at_max_o  out count is at SCALE-1
//   wrap_o    out advancing from SCALE-1 this cycle
module osd_rep_counter #(
  parameter int SCALE = 2
) (
  input  logic pclk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic adv_i,
  output logic at_max_o,
  output logic wrap_o
);

  localparam int CW = (SCALE > 1) ? $clog2(SCALE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == CW'(SCALE - 1));
  assign wrap_o   = adv_i & at_max_o;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (adv_i) begin
      cnt_d = at_max_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/osd_upsample_rd_ctrl.sv
// osd_upsample_rd_ctrl
// Read-side sequencer for the OSD region RAM. Turns the display's frame
// start pulse and per-pixel region-active strobe into read addresses that
// replicate each source pixel/line SCALE times, and owns the ping-pong
// bank handshake with the RAM writer.
// Ports:
//   pclk, rst_n       clock, synchronous active-low reset
//   i_frame_rst       frame-start pulse
//   i_region_active   pixel inside overlay region
//   i_wr_done         writer finished bank o_wr_bank
//   o_rd_en           RAM read enable
//   o_rd_addr         {rd_bank, pixel_index}
//   o_wr_bank         bank the writer may fill
//   o_busy            in ACTIVE
//   o_frame_done      pulse after the last output line
//   o_overrun         sticky: region line longer than SRC_W*SCALE
//
// state      | meaning
// WAIT_FRAME | after reset, nothing read until a frame start
// ACTIVE     | generating addresses for the current frame
// DONE       | all output lines issued, idle until next frame start
module osd_upsample_rd_ctrl
  import osd_pkg::*;
#(
  parameter int SRC_W  = OSD_SRC_W,
  parameter int SRC_H  = OSD_SRC_H,
  parameter int SCALE  = OSD_SCALE,
  parameter int ADDR_W = 11
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              i_frame_rst,
  input  logic              i_region_active,
  input  logic              i_wr_done,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_wr_bank,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_overrun
);

  localparam int PIX_W = ADDR_W - 1;

  osd_state_e       state_q, state_d;
  logic [PIX_W-1:0] src_x_q, src_x_d;
  logic [PIX_W-1:0] src_y_q, src_y_d;
  logic [PIX_W-1:0] line_base_q, line_base_d;
  logic             rd_bank_q, rd_bank_d;
  logic             pending_q, pending_d;
  logic             act_dly_q;
  logic             line_full_q, line_full_d;
  logic             overrun_q, overrun_d;
  logic             frame_done_q, frame_done_d;

  logic active_st, rd_en, line_end, final_end, sat;
  logic x_last, y_last;
  logic h_adv, h_clr, h_at_max, h_wrap;
  logic v_at_max, v_wrap;

  assign active_st = (state_q == ACTIVE);
  assign rd_en     = i_region_active & active_st;
  // A frame start in the same cycle swallows the line end.
  assign line_end  = act_dly_q & ~i_region_active & active_st & ~i_frame_rst;
  assign x_last    = (src_x_q == PIX_W'(SRC_W - 1));
  assign y_last    = (src_y_q == PIX_W'(SRC_H - 1));
  assign sat       = x_last & h_at_max;
  assign final_end = line_end & v_at_max & y_last;

  assign h_adv = rd_en & ~sat;
  // The final line keeps its horizontal position so the address holds
  // at the last pixel read while idle in DONE.
  assign h_clr = i_frame_rst | (line_end & ~final_end);

  osd_rep_counter #(.SCALE(SCALE)) u_h_rep (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .clr_i    (h_clr),
    .adv_i    (h_adv),
    .at_max_o (h_at_max),
    .wrap_o   (h_wrap)
  );

  osd_rep_counter #(.SCALE(SCALE)) u_v_rep (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .clr_i    (i_frame_rst),
    .adv_i    (line_end),
    .at_max_o (v_at_max),
    .wrap_o   (v_wrap)
  );

  always_comb begin
    state_d      = state_q;
    src_x_d      = src_x_q;
    src_y_d      = src_y_q;
    line_base_d  = line_base_q;
    line_full_d  = line_full_q;
    overrun_d    = overrun_q;
    frame_done_d = final_end;
    pending_d    = i_wr_done | (pending_q & ~i_frame_rst);
    rd_bank_d    = rd_bank_q ^ (i_frame_rst & pending_q);

    if (i_frame_rst) begin
      state_d     = ACTIVE;
      src_x_d     = '0;
      src_y_d     = '0;
      line_base_d = '0;
      line_full_d = 1'b0;
      overrun_d   = 1'b0;
    end else begin
      if (final_end) state_d = DONE;
      if (line_end) begin
        line_full_d = 1'b0;
        if (!final_end) src_x_d = '0;
        if (v_wrap && !y_last) begin
          src_y_d     = src_y_q + 1'b1;
          line_base_d = line_base_q + PIX_W'(SRC_W);
        end
      end else if (h_wrap) begin
        src_x_d = src_x_q + 1'b1;
      end
      // line_full marks that the last legal pixel has been read; any read
      // after that on the same line is an overrun.
      if (rd_en && sat) begin
        line_full_d = 1'b1;
        if (line_full_q) overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state_q      <= WAIT_FRAME;
      src_x_q      <= '0;
      src_y_q      <= '0;
      line_base_q  <= '0;
      rd_bank_q    <= 1'b0;
      pending_q    <= 1'b0;
      act_dly_q    <= 1'b0;
      line_full_q  <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_x_q      <= src_x_d;
      src_y_q      <= src_y_d;
      line_base_q  <= line_base_d;
      rd_bank_q    <= rd_bank_d;
      pending_q    <= pending_d;
      act_dly_q    <= i_region_active;
      line_full_q  <= line_full_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_rd_en      = rd_en;
  assign o_rd_addr    = {rd_bank_q, line_base_q + src_x_q};
  assign o_wr_bank    = ~rd_bank_q;
  assign o_busy       = active_st;
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_osd_upsample_rd_ctrl.sv
module tb_osd_upsample_rd_ctrl;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_frame_rst = 1'b0;
  logic        i_region_active = 1'b0;
  logic        i_wr_done = 1'b0;
  logic        o_rd_en;
  logic [10:0] o_rd_addr;
  logic        o_wr_bank, o_busy, o_frame_done, o_overrun;

  int total = 0;
  int bad = 0;

  logic        s_en, s_wb, s_busy, s_done, s_ovr;
  logic [10:0] s_addr;

  always #5 pclk = ~pclk;

  osd_upsample_rd_ctrl #(
    .SRC_W(32), .SRC_H(32), .SCALE(2), .ADDR_W(11)
  ) dut (
    .pclk            (pclk),
    .rst_n           (rst_n),
    .i_frame_rst     (i_frame_rst),
    .i_region_active (i_region_active),
    .i_wr_done       (i_wr_done),
    .o_rd_en         (o_rd_en),
    .o_rd_addr       (o_rd_addr),
    .o_wr_bank       (o_wr_bank),
    .o_busy          (o_busy),
    .o_frame_done    (o_frame_done),
    .o_overrun       (o_overrun)
  );

  // Reference address: bank*1024 + (line/2)*32 + min(pix/2, 31)
  function automatic logic [10:0] exp_addr(input int bank, input int line, input int pix);
    int x;
    x = pix / 2;
    if (x > 31) x = 31;
    return 11'(bank * 1024 + (line / 2) * 32 + x);
  endfunction

  // One pixel cycle: drive just after posedge, sample at negedge.
  task automatic px(input bit fr, input bit act, input bit wd);
    i_frame_rst     = fr;
    i_region_active = act;
    i_wr_done       = wd;
    @(negedge pclk);
    s_en   = o_rd_en;
    s_addr = o_rd_addr;
    s_wb   = o_wr_bank;
    s_busy = o_busy;
    s_done = o_frame_done;
    s_ovr  = o_overrun;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    px(0, 1, 0);
    px(0, 1, 0);
    rst_n = 1'b1;
    px(0, 1, 0);
    total++; if (s_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%0b exp=0", s_en); end
    total++; if (s_addr !== 11'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", s_addr); end
    total++; if (s_wb !== 1'b1) begin bad++; $display("FAIL reset_wr_bank got=%0b exp=1", s_wb); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", s_busy); end
    total++; if (s_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", s_done); end
    total++; if (s_ovr !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%0b exp=0", s_ovr); end
    px(0, 0, 0);
  endtask

  task automatic test_nominal();
    int dones = 0;
    px(1, 0, 0);
    for (int l = 0; l < 64; l++) begin
      for (int p = 0; p < 64; p++) begin
        px(0, 1, 0);
        dones += int'(s_done);
        total++;
        if (s_en !== 1'b1 || s_addr !== exp_addr(0, l, p)) begin
          bad++;
          $display("FAIL nom_addr l=%0d p=%0d got_en=%0b got=%0d exp=%0d", l, p, s_en, s_addr, exp_addr(0, l, p));
        end
      end
      px(0, 0, 0);
      dones += int'(s_done);
    end
    for (int i = 0; i < 3; i++) begin
      px(0, 0, 0);
      dones += int'(s_done);
    end
    total++; if (dones != 1) begin bad++; $display("FAIL nom_done_count got=%0d exp=1", dones); end
    total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL nom_busy got=%0b exp=0", s_busy); end
    total++; if (s_addr !== 11'd1023) begin bad++; $display("FAIL nom_last_addr got=%0d exp=1023", s_addr); end
    total++; if (s_ovr !== 1'b0) begin bad++; $display("FAIL nom_overrun got=%0b exp=0", s_ovr); end
    total++; if (s_wb !== 1'b1) begin bad++; $display("FAIL nom_wr_bank got=%0b exp=1", s_wb); end
  endtask

  task automatic test_bank_swap();
    px(1, 0, 0);
    for (int l = 0; l < 2; l++) begin
      for (int p = 0; p < 64; p++) begin
        px(0, 1, (l == 0 && p == 10));
        total++;
        if (s_addr !== exp_addr(0, l, p)) begin
          bad++;
          $display("FAIL swap_pre_addr l=%0d p=%0d got=%0d exp=%0d", l, p, s_addr, exp_addr(0, l, p));
        end
      end
      px(0, 0, 0);
    end
    total++; if (s_wb !== 1'b1) begin bad++; $display("FAIL swap_midframe_wr_bank got=%0b exp=1", s_wb); end
    px(1, 0, 0);
    for (int p = 0; p < 64; p++) begin
      px(0, 1, 0);
      total++;
      if (s_en !== 1'b1 || s_addr !== exp_addr(1, 0, p)) begin
        bad++;
        $display("FAIL swap_new_addr p=%0d got=%0d exp=%0d", p, s_addr, exp_addr(1, 0, p));
      end
    end
    total++; if (s_wb !== 1'b0) begin bad++; $display("FAIL swap_wr_bank got=%0b exp=0", s_wb); end
    px(0, 0, 0);
    px(1, 0, 0);
    px(0, 1, 0);
    total++; if (s_addr !== 11'd1024) begin bad++; $display("FAIL swap_keep_addr got=%0d exp=1024", s_addr); end
    total++; if (s_wb !== 1'b0) begin bad++; $display("FAIL swap_keep_wr_bank got=%0b exp=0", s_wb); end
    px(0, 0, 0);
  endtask

  task automatic test_coincident();
    px(0, 0, 1);
    px(1, 0, 1);
    px(0, 1, 0);
    total++; if (s_wb !== 1'b1 || s_addr !== 11'd0) begin
      bad++; $display("FAIL coinc_toggle got_wb=%0b got_addr=%0d exp_wb=1 exp_addr=0", s_wb, s_addr);
    end
    px(0, 0, 0);
    px(1, 0, 0);
    px(0, 1, 0);
    total++; if (s_wb !== 1'b0 || s_addr !== 11'd1024) begin
      bad++; $display("FAIL coinc_second_toggle got_wb=%0b got_addr=%0d exp_wb=0 exp_addr=1024", s_wb, s_addr);
    end
    px(0, 0, 0);
    px(1, 0, 0);
    px(0, 1, 0);
    total++; if (s_wb !== 1'b0 || s_addr !== 11'd1024) begin
      bad++; $display("FAIL coinc_no_third got_wb=%0b got_addr=%0d exp_wb=0 exp_addr=1024", s_wb, s_addr);
    end
    px(0, 0, 0);
  endtask

  task automatic test_overrun();
    px(1, 0, 0);
    for (int p = 0; p < 70; p++) begin
      px(0, 1, 0);
      total++;
      if (s_en !== 1'b1 || s_addr !== exp_addr(1, 0, p)) begin
        bad++;
        $display("FAIL ovr_addr p=%0d got=%0d exp=%0d", p, s_addr, exp_addr(1, 0, p));
      end
      total++;
      if (s_ovr !== (p >= 65)) begin
        bad++;
        $display("FAIL ovr_flag p=%0d got=%0b exp=%0b", p, s_ovr, (p >= 65));
      end
    end
    px(0, 0, 0);
    total++; if (s_ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%0b exp=1", s_ovr); end
    px(0, 1, 0);
    total++; if (s_addr !== 11'd1024) begin bad++; $display("FAIL ovr_realign got=%0d exp=1024", s_addr); end
    px(0, 0, 0);
    px(1, 0, 0);
    px(0, 0, 0);
    total++; if (s_ovr !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%0b exp=0", s_ovr); end
  endtask

  task automatic test_done_extra();
    int dones = 0;
    px(1, 0, 0);
    for (int l = 0; l < 66; l++) begin
      for (int p = 0; p < 64; p++) begin
        px(0, 1, 0);
        dones += int'(s_done);
        if (l < 64) begin
          total++;
          if (s_en !== 1'b1 || s_addr !== exp_addr(1, l, p)) begin
            bad++;
            $display("FAIL done_addr l=%0d p=%0d got=%0d exp=%0d", l, p, s_addr, exp_addr(1, l, p));
          end
        end else begin
          total++;
          if (s_en !== 1'b0 || s_busy !== 1'b0 || s_addr !== 11'd2047) begin
            bad++;
            $display("FAIL done_extra l=%0d p=%0d got_en=%0b got_busy=%0b got_addr=%0d exp 0/0/2047",
                     l, p, s_en, s_busy, s_addr);
          end
        end
      end
      px(0, 0, 0);
      dones += int'(s_done);
      px(0, 0, 0);
      dones += int'(s_done);
    end
    total++; if (dones != 1) begin bad++; $display("FAIL done_count got=%0d exp=1", dones); end
  endtask

  task automatic test_reset_mid();
    px(1, 0, 0);
    for (int l = 0; l < 10; l++) begin
      for (int p = 0; p < 64; p++) px(0, 1, 0);
      px(0, 0, 0);
    end
    for (int p = 0; p < 20; p++) px(0, 1, 0);
    total++; if (s_addr !== exp_addr(1, 10, 19)) begin
      bad++; $display("FAIL rmid_pre_addr got=%0d exp=%0d", s_addr, exp_addr(1, 10, 19));
    end
    rst_n = 1'b0;
    px(0, 1, 0);
    rst_n = 1'b1;
    for (int l = 0; l < 3; l++) begin
      for (int p = 0; p < 64; p++) begin
        px(0, 1, 0);
        total++;
        if (s_en !== 1'b0 || s_addr !== 11'd0 || s_busy !== 1'b0) begin
          bad++;
          $display("FAIL rmid_idle l=%0d p=%0d got_en=%0b got_addr=%0d got_busy=%0b", l, p, s_en, s_addr, s_busy);
        end
      end
      px(0, 0, 0);
    end
    total++; if (s_wb !== 1'b1) begin bad++; $display("FAIL rmid_wr_bank got=%0b exp=1", s_wb); end
    total++; if (s_done !== 1'b0 || s_ovr !== 1'b0) begin
      bad++; $display("FAIL rmid_flags got_done=%0b got_ovr=%0b exp 0/0", s_done, s_ovr);
    end
    px(1, 0, 0);
    px(0, 1, 0);
    total++; if (s_en !== 1'b1 || s_addr !== 11'd0) begin
      bad++; $display("FAIL rmid_restart got_en=%0b got_addr=%0d exp 1/0", s_en, s_addr);
    end
    px(0, 0, 0);
  endtask

  initial begin
    @(posedge pclk);
    #1;
    test_reset();
    test_nominal();
    test_bank_swap();
    test_coincident();
    test_overrun();
    test_done_extra();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
